// File: rtl/popcnt_seq.sv
// popcnt_seq: counts the ACT-valued bits of a wide vector, CHUNK bits per cycle, using one shared cnt_bits.
// Latency: NCHUNK+1 edges from accept to out_valid. With POPCNT_EARLY_EXIT_EN it is k+1 (k = last active slice).
// Backpressure: in_ready is low outside IDLE. The result waits in HOLD until out_ready is seen.

`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

// cnt_bits: combinational count of the bits of in equal to ACT.
// Latency: 0 cycles.
// Backpressure: none (pure combinational).
module cnt_bits #(
  parameter int   IN  = 64,
  parameter logic ACT = `High
) (
  input  logic [IN-1:0]      in,
  output logic [$clog2(IN):0] out
);
  localparam int OUT = $clog2(IN) + 1;

  always_comb begin
    out = '0;
    for (int i = 0; i < IN; i++) out = out + OUT'(in[i] == ACT);
  end
endmodule

module popcnt_seq #(
  parameter int   IN    = 512,
  parameter int   CHUNK = 64,
  parameter logic ACT   = `High
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN-1:0]       in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [$clog2(IN):0] out,
  output logic                busy
);
  localparam int NCHUNK = (IN + CHUNK - 1) / CHUNK;
  localparam int OUT    = $clog2(IN) + 1;
  localparam int W      = NCHUNK * CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t               state, state_nxt;
  logic [W-1:0]         sreg, sreg_load, sreg_shift;
  logic [OUT-1:0]       acc, sum;
  logic [$clog2(CHUNK):0] slice_cnt;
  logic [IDXW-1:0]      idx;
  logic                 last;

  cnt_bits #(.IN(CHUNK), .ACT(ACT)) u_cnt (
    .in  (sreg[CHUNK-1:0]),
    .out (slice_cnt)
  );

  assign sum = acc + OUT'(slice_cnt);

  // Padding above IN is loaded inactive so it never contributes to the count.
  always_comb begin
    sreg_load         = {W{~ACT}};
    sreg_load[IN-1:0] = in;
  end

  assign sreg_shift = ACT ? (sreg >> CHUNK) : ~((~sreg) >> CHUNK);

`ifdef POPCNT_EARLY_EXIT_EN
  logic more;
  assign more = ACT ? (|sreg_shift) : ~(&sreg_shift);
  assign last = (idx == IDXW'(NCHUNK - 1)) || !more;
`else
  assign last = (idx == IDXW'(NCHUNK - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last)     state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == RUN);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      acc  <= '0;
      idx  <= '0;
      out  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sreg <= sreg_load;
          acc  <= '0;
          idx  <= '0;
        end
        RUN: begin
          sreg <= sreg_shift;
          acc  <= sum;
          idx  <= idx + 1'b1;
          if (last) out <= sum;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_popcnt_seq.sv
// Directed and randomized checks of popcnt_seq: instance a (512/64, High) and instance b (100/32, Low).
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module tb_popcnt_seq;
`ifdef POPCNT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic         a_in_ready, a_out_valid, a_busy;
  logic [511:0] a_in = '0;
  logic [9:0]   a_out;
  logic         b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic         b_in_ready, b_out_valid, b_busy;
  logic [99:0]  b_in = '0;
  logic [7:0]   b_out;

  int n_vec  = 0;
  int n_miss = 0;

  popcnt_seq #(.IN(512), .CHUNK(64), .ACT(`High)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .in(a_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out), .busy(a_busy)
  );

  popcnt_seq #(.IN(100), .CHUNK(32), .ACT(`Low)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out), .busy(b_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present v until accepted; lat counts edges from the accept edge (inclusive) to out_valid.
  task automatic a_send(input logic [511:0] v, output int lat);
    int t = 0;
    a_in = v;
    a_in_valid = 1'b1;
    while (!a_in_ready && t < 50) begin tick(); t++; end
    tick();
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic b_send(input logic [99:0] v, output int lat);
    int t = 0;
    b_in = v;
    b_in_valid = 1'b1;
    while (!b_in_ready && t < 50) begin tick(); t++; end
    tick();
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic a_take;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic b_take;
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  function automatic int lat_a(input logic [511:0] v);
    int k = 1;
    for (int i = 0; i < 512; i++) if (v[i]) k = i / 64 + 1;
    return EE ? k + 1 : 9;
  endfunction

  function automatic int lat_b(input logic [99:0] v);
    int k = 1;
    for (int i = 0; i < 100; i++) if (!v[i]) k = i / 32 + 1;
    return EE ? k + 1 : 5;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    a_in_valid = 1'b1; a_in = '1;
    b_in_valid = 1'b1;
    tick(); tick();
    n_vec++;
    if ({a_in_ready, a_out_valid, a_busy, a_out} !== {1'b1, 1'b0, 1'b0, 10'd0}) begin
      n_miss++;
      $display("FAIL reset_a rdy/vld/busy/out got %b/%b/%b/%0d want 1/0/0/0", a_in_ready, a_out_valid, a_busy, a_out);
    end
    n_vec++;
    if ({b_in_ready, b_out_valid, b_busy, b_out} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_miss++;
      $display("FAIL reset_b rdy/vld/busy/out got %b/%b/%b/%0d want 1/0/0/0", b_in_ready, b_out_valid, b_busy, b_out);
    end
    reset = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_all_ones_hold;
    int lat;
    a_send('1, lat);
    n_vec++;
    if (lat != 9) begin n_miss++; $display("FAIL ones_latency got %0d want 9", lat); end
    n_vec++;
    if (a_out !== 10'd512) begin n_miss++; $display("FAIL ones_out got %0d want 512", a_out); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if ({a_out_valid, a_in_ready, a_out} !== {1'b1, 1'b0, 10'd512}) begin
        n_miss++;
        $display("FAIL ones_hold cyc%0d vld/rdy/out got %b/%b/%0d want 1/0/512", c, a_out_valid, a_in_ready, a_out);
      end
    end
    a_take();
    n_vec++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      n_miss++;
      $display("FAIL ones_release rdy/vld got %b/%b want 1/0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_padding_low;
    int lat;
    logic [99:0] v;
    b_send('0, lat);
    n_vec++;
    if (b_out !== 8'd100 || lat != 5) begin
      n_miss++; $display("FAIL pad_zeros out/lat got %0d/%0d want 100/5", b_out, lat);
    end
    b_take();
    b_send('1, lat);
    n_vec++;
    if (b_out !== 8'd0 || lat != (EE ? 2 : 5)) begin
      n_miss++; $display("FAIL pad_ones out/lat got %0d/%0d want 0/%0d", b_out, lat, EE ? 2 : 5);
    end
    b_take();
    v = '1; v[3:0] = 4'h0;
    b_send(v, lat);
    n_vec++;
    if (b_out !== 8'd4 || lat != (EE ? 2 : 5)) begin
      n_miss++; $display("FAIL pad_low4 out/lat got %0d/%0d want 4/%0d", b_out, lat, EE ? 2 : 5);
    end
    b_take();
    v = '1; v[99] = 1'b0;
    b_send(v, lat);
    n_vec++;
    if (b_out !== 8'd1 || lat != 5) begin
      n_miss++; $display("FAIL pad_top out/lat got %0d/%0d want 1/5", b_out, lat);
    end
    b_take();
  endtask

  task automatic test_early_exit;
    int lat;
    logic [511:0] v;
    v = '0; v[0] = 1'b1; v[511] = 1'b1;
    a_send(v, lat);
    n_vec++;
    if (a_out !== 10'd2 || lat != 9) begin
      n_miss++; $display("FAIL ee_ends out/lat got %0d/%0d want 2/9", a_out, lat);
    end
    a_take();
    v = '0; v[3] = 1'b1;
    a_send(v, lat);
    n_vec++;
    if (a_out !== 10'd1 || lat != (EE ? 2 : 9)) begin
      n_miss++; $display("FAIL ee_bit3 out/lat got %0d/%0d want 1/%0d", a_out, lat, EE ? 2 : 9);
    end
    a_take();
    v = '0; v[64] = 1'b1; v[65] = 1'b1;
    a_send(v, lat);
    n_vec++;
    if (a_out !== 10'd2 || lat != (EE ? 3 : 9)) begin
      n_miss++; $display("FAIL ee_slice2 out/lat got %0d/%0d want 2/%0d", a_out, lat, EE ? 3 : 9);
    end
    a_take();
    a_send('0, lat);
    n_vec++;
    if (a_out !== 10'd0 || lat != (EE ? 2 : 9)) begin
      n_miss++; $display("FAIL ee_zero out/lat got %0d/%0d want 0/%0d", a_out, lat, EE ? 2 : 9);
    end
    a_take();
  endtask

  task automatic test_in_valid_ignored;
    int t = 0;
    int bad = 0;
    int lat;
    a_in = '0; a_in[7:0] = 8'hFF;
    a_in_valid = 1'b1;
    tick();
    while (!a_out_valid && t < 50) begin
      a_in = ~a_in;
      if (a_in_ready) bad++;
      tick(); t++;
    end
    for (int c = 0; c < 2; c++) begin
      a_in = ~a_in;
      if (a_in_ready) bad++;
      tick();
    end
    n_vec++;
    if (bad != 0) begin n_miss++; $display("FAIL ign_ready_high got %0d cycles want 0", bad); end
    n_vec++;
    if (a_out !== 10'd8 || !a_out_valid) begin
      n_miss++; $display("FAIL ign_out vld/out got %b/%0d want 1/8", a_out_valid, a_out);
    end
    a_in = '1;
    a_take();
    n_vec++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      n_miss++; $display("FAIL ign_release rdy/vld got %b/%b want 1/0", a_in_ready, a_out_valid);
    end
    tick();
    a_in_valid = 1'b0;
    n_vec++;
    if (a_busy !== 1'b1) begin n_miss++; $display("FAIL ign_reaccept busy got %b want 1", a_busy); end
    lat = 1;
    while (!a_out_valid && lat < 50) begin tick(); lat++; end
    n_vec++;
    if (a_out !== 10'd512) begin n_miss++; $display("FAIL ign_second out got %0d want 512", a_out); end
    a_take();
  endtask

  task automatic test_reset_mid_run;
    int lat;
    a_in = '1;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick(); tick(); tick();
    n_vec++;
    if (a_busy !== 1'b1) begin n_miss++; $display("FAIL midrst_busy got %b want 1", a_busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({a_in_ready, a_out_valid, a_busy, a_out} !== {1'b1, 1'b0, 1'b0, 10'd0}) begin
      n_miss++;
      $display("FAIL midrst_state rdy/vld/busy/out got %b/%b/%b/%0d want 1/0/0/0", a_in_ready, a_out_valid, a_busy, a_out);
    end
    a_send(512'h0F, lat);
    n_vec++;
    if (a_out !== 10'd4 || lat != (EE ? 2 : 9)) begin
      n_miss++; $display("FAIL midrst_after out/lat got %0d/%0d want 4/%0d", a_out, lat, EE ? 2 : 9);
    end
    a_take();
  endtask

  task automatic test_back_to_back;
    int lat, exp, stall;
    logic [511:0] va;
    logic [99:0]  vb;
    for (int n = 0; n < 1000; n++) begin
      for (int w = 0; w < 16; w++) va[w*32 +: 32] = $urandom;
      case ($urandom_range(0, 3))
        1: va = va >> $urandom_range(0, 511);
        2: va = '0;
        3: begin va = '0; va[$urandom_range(0, 511)] = 1'b1; end
        default: ;
      endcase
      exp = $countones(va);
      a_send(va, lat);
      n_vec++;
      if (a_out !== 10'(exp) || lat != lat_a(va)) begin
        n_miss++; $display("FAIL rnd_a #%0d out/lat got %0d/%0d want %0d/%0d", n, a_out, lat, exp, lat_a(va));
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        tick();
        n_vec++;
        if (!a_out_valid || a_out !== 10'(exp)) begin
          n_miss++; $display("FAIL rnd_a_stall #%0d vld/out got %b/%0d want 1/%0d", n, a_out_valid, a_out, exp);
        end
      end
      a_take();
    end
    for (int n = 0; n < 300; n++) begin
      vb = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        1: vb = ~((~vb) >> $urandom_range(0, 99));
        2: vb = '1;
        3: begin vb = '1; vb[$urandom_range(0, 99)] = 1'b0; end
        default: ;
      endcase
      exp = 100 - $countones(vb);
      b_send(vb, lat);
      n_vec++;
      if (b_out !== 8'(exp) || lat != lat_b(vb)) begin
        n_miss++; $display("FAIL rnd_b #%0d out/lat got %0d/%0d want %0d/%0d", n, b_out, lat, exp, lat_b(vb));
      end
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        tick();
        n_vec++;
        if (!b_out_valid || b_out !== 8'(exp)) begin
          n_miss++; $display("FAIL rnd_b_stall #%0d vld/out got %b/%0d want 1/%0d", n, b_out_valid, b_out, exp);
        end
      end
      b_take();
    end
  endtask

  initial begin
    test_reset();
    test_all_ones_hold();
    test_padding_low();
    test_early_exit();
    test_in_valid_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
